// File: rtl/pla_eval_pkg.sv
// Shared types and default sizes for the restricted PLA evaluator.
// One cube is a product term: enable, literal-present mask, literal polarity.
package pla_eval_pkg;

  localparam int PLA_N_IN   = 7;
  localparam int PLA_N_CUBE = 16;

  typedef struct packed {
    logic                en;
    logic [PLA_N_IN-1:0] care;
    logic [PLA_N_IN-1:0] val;
  } cube_t;

endpackage

// File: rtl/pla_restrict_eval_if.sv
// Configuration port and valid/ready streams of the restricted PLA evaluator.
// master = the side that writes cubes and supplies vectors, slave = the evaluator.
interface pla_restrict_eval_if import pla_eval_pkg::*; #(
  parameter int N_IN   = PLA_N_IN,
  parameter int N_CUBE = PLA_N_CUBE
);
  localparam int AW = $clog2(N_CUBE);

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [N_IN-1:0]   cfg_care;
  logic [N_IN-1:0]   cfg_val;
  logic              cfg_en;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_x;
  logic [N_IN-1:0]   in_shift;
  logic              out_valid;
  logic              out_ready;
  logic              out_y;
  logic [N_CUBE-1:0] out_hit;

  modport master (
    output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_en,
    output in_valid, in_x, in_shift, out_ready,
    input  in_ready, out_valid, out_y, out_hit
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_en,
    input  in_valid, in_x, in_shift, out_ready,
    output in_ready, out_valid, out_y, out_hit
  );

endinterface

// File: rtl/pla_cube_match.sv
// Combinational matcher for one product term: every cared literal must agree with z.
module pla_cube_match import pla_eval_pkg::*; #(
  parameter int N_IN = PLA_N_IN
) (
  input  cube_t           cube_i,
  input  logic [N_IN-1:0] z_i,
  output logic            match_o
);

  // An enabled cube with an empty care mask is a tautology.
  assign match_o = cube_i.en && (((z_i ^ cube_i.val) & cube_i.care) == '0);

endmodule

// File: rtl/pla_restrict_eval.sv
// Two-stage evaluator of a sum-of-products table on in_x ^ in_shift.
// Optional macro PLA_EVAL_CNT_EN adds a saturating count of delivered out_y = 1 results.
module pla_restrict_eval import pla_eval_pkg::*; #(
  parameter int N_IN   = PLA_N_IN,
  parameter int N_CUBE = PLA_N_CUBE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pla_restrict_eval_if.slave   bus
`ifdef PLA_EVAL_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [15:0]          one_cnt
`endif
);

  localparam int AW = $clog2(N_CUBE);

  cube_t             table_q [N_CUBE];
  logic              s1_vld_q;
  logic [N_IN-1:0]   s1_z_q;
  logic              s2_vld_q;
  logic              s2_y_q;
  logic [N_CUBE-1:0] s2_hit_q;
  logic [N_CUBE-1:0] hit_d;
  logic              s2_adv;
  logic              s1_adv;
  logic              accept;

  assign s2_adv       = !s2_vld_q || bus.out_ready;
  assign s1_adv       = !s1_vld_q || s2_adv;
  assign accept       = bus.in_valid && s1_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CUBE; i++) table_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CUBE; i++) begin
        if (bus.cfg_we && (bus.cfg_addr == AW'(i))) begin
          table_q[i] <= '{en: bus.cfg_en, care: bus.cfg_care, val: bus.cfg_val};
        end
      end
    end
  end

  // The table is read as it stands at the edge where S1 moves into S2,
  // so a vector stalled in S1 sees every write made while it waits.
  generate
    for (genvar gi = 0; gi < N_CUBE; gi++) begin : g_cube
      pla_cube_match #(.N_IN(N_IN)) u_match (
        .cube_i  (table_q[gi]),
        .z_i     (s1_z_q),
        .match_o (hit_d[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_z_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_y_q   <= 1'b0;
      s2_hit_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= accept;
        if (accept) s1_z_q <= bus.in_x ^ bus.in_shift;
      end
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        s2_y_q   <= s1_vld_q && (|hit_d);
        s2_hit_q <= s1_vld_q ? hit_d : '0;
      end
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.out_y     = s2_y_q;
  assign bus.out_hit   = s2_hit_q;

`ifdef PLA_EVAL_CNT_EN
  logic [15:0] one_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      one_cnt_q <= '0;
    end else if (cnt_clr) begin
      one_cnt_q <= '0;
    end else if (s2_vld_q && bus.out_ready && s2_y_q && (one_cnt_q != 16'hFFFF)) begin
      one_cnt_q <= one_cnt_q + 16'd1;
    end
  end

  assign one_cnt = one_cnt_q;
`endif

endmodule

// File: tb/tb_pla_restrict_eval.sv
// Directed bench for pla_restrict_eval with a cube-table model and result scoreboard.
// Honours PLA_EVAL_CNT_EN the same way as the design.
module tb_pla_restrict_eval;
  import pla_eval_pkg::*;

  localparam int NI = PLA_N_IN;
  localparam int NC = PLA_N_CUBE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pla_restrict_eval_if bus ();

`ifdef PLA_EVAL_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] one_cnt;
`endif

  pla_restrict_eval dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PLA_EVAL_CNT_EN
    ,
    .cnt_clr (cnt_clr),
    .one_cnt (one_cnt)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Model: cube table plus the ordered results the design owes downstream.
  typedef struct packed { logic y; logic [NC-1:0] hit; } res_t;
  bit          m_en   [NC];
  bit [NI-1:0] m_care [NC];
  bit [NI-1:0] m_val  [NC];
  res_t        expq [$];
  int          n_xfer = 0;
  int unsigned m_cnt  = 0;

  function automatic res_t m_eval(input bit [NI-1:0] z);
    res_t r;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      bit ok;
      ok = m_en[c];
      for (int b = 0; b < NI; b++)
        if (m_care[c][b] && (z[b] != m_val[c][b])) ok = 0;
      r.hit[c] = ok;
      if (ok) r.y = 1'b1;
    end
    return r;
  endfunction

  bit          hold;
  bit          hold_y;
  bit [NC-1:0] hold_hit;

  always @(negedge clk) begin
    res_t r;
    bit   inc;
    inc = 0;
    if (!rst_n) begin
      expq.delete();
      for (int c = 0; c < NC; c++) begin m_en[c] = 0; m_care[c] = '0; m_val[c] = '0; end
      hold  = 0;
      m_cnt = 0;
    end else begin
`ifdef PLA_EVAL_CNT_EN
      chk("one_cnt", one_cnt, m_cnt);
`endif
      if (hold) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_y", bus.out_y, hold_y);
        chk("stall_hit", bus.out_hit, hold_hit);
      end
      hold = 0;
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL extra_result: out_valid with y=%0b hit='h%0h, expected none at %0t",
                   bus.out_y, bus.out_hit, $time);
        end else begin
          r = expq[0];
          chk("res_y", bus.out_y, r.y);
          chk("res_hit", bus.out_hit, r.hit);
          if (bus.out_ready) begin
            void'(expq.pop_front());
            n_xfer++;
            inc = r.y;
          end else begin
            hold = 1; hold_y = bus.out_y; hold_hit = bus.out_hit;
          end
        end
      end
`ifdef PLA_EVAL_CNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (inc && m_cnt < 32'hFFFF) m_cnt++;
`endif
      // A write at this edge precedes any evaluation of a vector accepted at it.
      if (bus.cfg_we) begin
        m_en[bus.cfg_addr]   = bus.cfg_en;
        m_care[bus.cfg_addr] = bus.cfg_care;
        m_val[bus.cfg_addr]  = bus.cfg_val;
      end
      if (bus.in_valid && bus.in_ready) expq.push_back(m_eval(bus.in_x ^ bus.in_shift));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [NI-1:0] care, input logic [NI-1:0] val,
                           input logic en);
    bus.cfg_we = 1'b1; bus.cfg_addr = a[3:0]; bus.cfg_care = care; bus.cfg_val = val;
    bus.cfg_en = en;
    tick();
    bus.cfg_we = 1'b0;
    $display("cfg cube%0d en=%0b care=%b val=%b", a, en, care, val);
  endtask

  task automatic single(input string name, input logic [NI-1:0] x, input logic [NI-1:0] s,
                        input logic ey, input logic [NC-1:0] ehit);
    bus.in_valid = 1'b1; bus.in_x = x; bus.in_shift = s;
    tick();
    bus.in_valid = 1'b0;
    chk({name, "_lat1"}, bus.out_valid, 0);
    tick();
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_y"}, bus.out_y, ey);
    chk({name, "_hit"}, bus.out_hit, ehit);
    $display("vec %s x=%b shift=%b -> y=%0b hit=%h", name, x, s, bus.out_y, bus.out_hit);
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 50) begin tick(); n++; end
    chk("drain_outstanding", expq.size(), 0);
    tick();
  endtask

  logic [NI-1:0] vx [8];
  logic [NI-1:0] vs [8];

  initial begin
    int idx;
    int cyc;
    int n0;
    bit acc;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_care = '0; bus.cfg_val = '0; bus.cfg_en = 0;
    bus.in_valid = 0; bus.in_x = '0; bus.in_shift = '0; bus.out_ready = 1'b1;
    vx = '{7'b0000011, 7'b1000000, 7'b0000000, 7'b1111111,
           7'b0101010, 7'b1010101, 7'b0010100, 7'b1100011};
    vs = '{7'b0000000, 7'b0000000, 7'b0010100, 7'b0000000,
           7'b0000001, 7'b0000000, 7'b0010100, 7'b0100000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_y", bus.out_y, 0);
    chk("rst_hit", bus.out_hit, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);

    cfg_write(0, 7'b0000011, 7'b0000011, 1'b1);
    single("basic", 7'b0000011, 7'b0000000, 1'b1, 16'h0001);
    single("shift", 7'b0000001, 7'b0000010, 1'b1, 16'h0001);
    single("noshift", 7'b0000001, 7'b0000000, 1'b0, 16'h0000);

    // Cube1 becomes a tautology while the first vector sits in S1.
    bus.in_valid = 1'b1; bus.in_x = '0; bus.in_shift = '0;
    tick();
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd1; bus.cfg_care = '0; bus.cfg_val = '0; bus.cfg_en = 1'b1;
    tick();
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    chk("wr_old_valid", bus.out_valid, 1);
    chk("wr_old_y", bus.out_y, 0);
    chk("wr_old_hit", bus.out_hit, 16'h0000);
    tick();
    chk("wr_new_valid", bus.out_valid, 1);
    chk("wr_new_y", bus.out_y, 1);
    chk("wr_new_hit", bus.out_hit, 16'h0002);
    $display("vec wr_new y=%0b hit=%h", bus.out_y, bus.out_hit);
    tick();

    cfg_write(1, 7'b0000000, 7'b0000000, 1'b0);
    cfg_write(2, 7'b1100000, 7'b1000000, 1'b1);
    cfg_write(5, 7'b0010100, 7'b0000000, 1'b1);
    idx = 0; cyc = 0; n0 = n_xfer;
    while (idx < 8 && cyc < 100) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid = 1'b1; bus.in_x = vx[idx]; bus.in_shift = vs[idx];
      #1;
      acc = bus.in_ready;
      tick();
      if (acc) begin
        $display("stream cycle %0d accepted vec%0d x=%b shift=%b", cyc, idx, vx[idx], vs[idx]);
        idx++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain();
    chk("stream_count", n_xfer - n0, 8);

    // Reset with one vector in S2 and one in S1.
    bus.in_valid = 1'b1; bus.in_x = 7'b0000011; bus.in_shift = '0;
    tick();
    bus.in_x = 7'b1000000;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_y", bus.out_y, 0);
    chk("arst_hit", bus.out_hit, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_idle", bus.out_valid, 0);
    single("empty_tbl", 7'b0000011, 7'b0000000, 1'b0, 16'h0000);

`ifdef PLA_EVAL_CNT_EN
    cfg_write(1, 7'b0000000, 7'b0000000, 1'b1);
    bus.in_valid = 1'b1; bus.in_x = '0; bus.in_shift = '0;
    repeat (70000) tick();
    bus.in_valid = 1'b0;
    drain();
    chk("cnt_sat", one_cnt, 16'hFFFF);
    $display("cnt after 70000 ones: %h", one_cnt);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr", one_cnt, 16'h0000);
    $display("cnt after clear: %h", one_cnt);
`endif

    chk("final_outstanding", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
